// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch core and its display mux.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0] SSD_OFF  = 4'b1111;
    localparam logic [3:0] SSD_DIG0 = 4'b1110;
    localparam logic [3:0] SSD_DIG1 = 4'b1101;
    localparam logic [3:0] SSD_DIG2 = 4'b1011;
    localparam logic [3:0] SSD_DIG3 = 4'b0111;

endpackage

// File: rtl/stopwatch_if.sv
// Control and display signals between the divider/buttons, the core and the segment decoder.
interface stopwatch_if;
    import stopwatch_pkg::*;

    // Buttons are one-cycle pulses with no backpressure; every core output is registered and valid each cycle.
    logic        clk_1hz;
    logic [1:0]  scan;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic        running;
    logic        lap_active;
    logic [15:0] time_bcd;
    logic        wrap;
    logic [3:0]  ssd_ctl;
    logic [3:0]  bcd;
    sw_state_e   state_dbg;

    modport master (
        output clk_1hz, scan, start_stop, lap, clear,
        input  running, lap_active, time_bcd, wrap, ssd_ctl, bcd, state_dbg
    );

    modport slave (
        input  clk_1hz, scan, start_stop, lap, clear,
        output running, lap_active, time_bcd, wrap, ssd_ctl, bcd, state_dbg
    );
endinterface

// File: rtl/tick_sync.sv
// Two-flop synchronizer plus rising-edge detect: one-cycle tick per async_in rising edge.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);
    logic sync1_q, sync2_q, hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~hist_q;
endmodule

// File: rtl/stopwatch_core.sv
// mm:ss BCD stopwatch with start/stop, lap hold and clear, driving a 4-digit multiplexed display.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  sw
);
    logic tick;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sw.clk_1hz),
        .tick     (tick)
    );

    sw_state_e   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] lap_q, lap_d;
    logic        running_q, running_d;
    logic        lap_active_q, lap_active_d;
    logic        wrap_q, wrap_d;
    logic [3:0]  ssd_ctl_q, ssd_ctl_d;
    bcd_t        bcd_q, bcd_d;

    bcd_t        s0, s1, m0, m1;
    bcd_t        n_s0, n_s1, n_m0, n_m1;
    logic        s0_max, s1_max, m0_max, m1_max;
    logic        inc;
    logic [15:0] disp;

    // Ripple-carry BCD increment of the live count.
    always_comb begin
        s0     = count_q[3:0];
        s1     = count_q[7:4];
        m0     = count_q[11:8];
        m1     = count_q[15:12];
        s0_max = (s0 == 4'd9);
        s1_max = (s1 == bcd_t'(SEC_TENS_MAX));
        m0_max = (m0 == 4'd9);
        m1_max = (m1 == bcd_t'(MIN_TENS_MAX));
        n_s0   = s0_max ? 4'd0 : s0 + 4'd1;
        n_s1   = s0;
        n_s1   = s1;
        n_m0   = m0;
        n_m1   = m1;
        if (s0_max) begin
            n_s1 = s1_max ? 4'd0 : s1 + 4'd1;
        end
        if (s0_max && s1_max) begin
            n_m0 = m0_max ? 4'd0 : m0 + 4'd1;
        end
        if (s0_max && s1_max && m0_max) begin
            n_m1 = m1_max ? 4'd0 : m1 + 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        wrap_d       = 1'b0;
        inc          = (state_q == ST_RUN) && tick;

        if (inc) begin
            count_d = {n_m1, n_m0, n_s1, n_s0};
            wrap_d  = s0_max && s1_max && m0_max && m1_max;
        end

        if (sw.start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Lap register captures the count as it stood before this cycle's increment.
        if (sw.lap && (state_q != ST_IDLE)) begin
            lap_active_d = ~lap_active_q;
            if (!lap_active_q) begin
                lap_d = count_q;
            end
        end

        if (sw.clear) begin
            state_d      = ST_IDLE;
            count_d      = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            wrap_d       = 1'b0;
        end

        running_d = (state_d == ST_RUN);
    end

    always_comb begin
        disp      = lap_active_q ? lap_q : count_q;
        ssd_ctl_d = SSD_DIG0;
        bcd_d     = disp[3:0];
        case (sw.scan)
            2'd0: begin ssd_ctl_d = SSD_DIG0; bcd_d = disp[3:0];   end
            2'd1: begin ssd_ctl_d = SSD_DIG1; bcd_d = disp[7:4];   end
            2'd2: begin ssd_ctl_d = SSD_DIG2; bcd_d = disp[11:8];  end
            2'd3: begin ssd_ctl_d = SSD_DIG3; bcd_d = disp[15:12]; end
            default: begin ssd_ctl_d = SSD_OFF; bcd_d = 4'h0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
            ssd_ctl_q    <= SSD_OFF;
            bcd_q        <= 4'h0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            wrap_q       <= wrap_d;
            ssd_ctl_q    <= ssd_ctl_d;
            bcd_q        <= bcd_d;
        end
    end

    assign sw.running    = running_q;
    assign sw.lap_active = lap_active_q;
    assign sw.time_bcd   = count_q;
    assign sw.wrap       = wrap_q;
    assign sw.ssd_ctl    = ssd_ctl_q;
    assign sw.bcd        = bcd_q;
    assign sw.state_dbg  = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core against a seconds-based behavioural model.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  logic clk;
  logic rst;
  stopwatch_if sw_if ();

  stopwatch_core #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: time kept as plain seconds
  int        m_sec     = 0;
  int        m_lap_sec = 0;
  bit        m_lap_act = 1'b0;
  sw_state_e m_mode    = ST_IDLE;

  function automatic logic [15:0] to_bcd(input int sec);
    int m, s;
    logic [3:0] d3, d2, d1, d0;
    m  = sec / 60;
    s  = sec % 60;
    d3 = 4'(m / 10);
    d2 = 4'(m % 10);
    d1 = 4'(s / 10);
    d0 = 4'(s % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_time"}, 32'(sw_if.time_bcd), 32'(to_bcd(m_sec)));
    check_eq({tag, "_running"}, 32'(sw_if.running), 32'(m_mode == ST_RUN));
    check_eq({tag, "_lap_active"}, 32'(sw_if.lap_active), 32'(m_lap_act));
    check_eq({tag, "_state"}, 32'(sw_if.state_dbg), 32'(m_mode));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_time"}, 32'(sw_if.time_bcd), 32'h0);
    check_eq({tag, "_running"}, 32'(sw_if.running), 32'h0);
    check_eq({tag, "_lap_active"}, 32'(sw_if.lap_active), 32'h0);
    check_eq({tag, "_wrap"}, 32'(sw_if.wrap), 32'h0);
    check_eq({tag, "_ssd_ctl"}, 32'(sw_if.ssd_ctl), 32'hF);
    check_eq({tag, "_bcd"}, 32'(sw_if.bcd), 32'h0);
    check_eq({tag, "_state"}, 32'(sw_if.state_dbg), 32'(ST_IDLE));
  endtask

  function automatic void model_start();
    case (m_mode)
      ST_IDLE:  m_mode = ST_RUN;
      ST_RUN:   m_mode = ST_PAUSE;
      default:  m_mode = ST_RUN;
    endcase
  endfunction

  function automatic void model_clear();
    m_mode = ST_IDLE; m_sec = 0; m_lap_sec = 0; m_lap_act = 1'b0;
  endfunction

  // driver tasks
  // One clk_1hz rising edge; optionally a start_stop pulse in the same cycle as the resulting tick.
  task automatic tick_1hz(input bit with_start);
    int wraps;
    int exp_wraps;
    @(posedge clk); #1 sw_if.clk_1hz = 1'b1;
    @(posedge clk);                       // edge k: first sample high
    @(posedge clk);                       // edge k+1: tick now high
    #1 sw_if.clk_1hz = 1'b0;
    if (with_start) sw_if.start_stop = 1'b1;
    @(negedge clk);
    check_eq("pre_tick_time", 32'(sw_if.time_bcd), 32'(to_bcd(m_sec)));
    wraps = 32'(sw_if.wrap);
    exp_wraps = (m_mode == ST_RUN && m_sec == 3599) ? 1 : 0;
    if (m_mode == ST_RUN) m_sec = (m_sec + 1) % 3600;
    if (with_start) model_start();
    @(posedge clk);                       // edge k+2: count changes
    #1 sw_if.start_stop = 1'b0;
    @(negedge clk);
    wraps += 32'(sw_if.wrap);
    check_status("post_tick");
    @(negedge clk);
    wraps += 32'(sw_if.wrap);
    check_eq("wrap_pulses", 32'(wraps), 32'(exp_wraps));
  endtask

  task automatic press(input int which);
    @(posedge clk); #1;
    case (which)
      0: sw_if.start_stop = 1'b1;
      1: sw_if.lap = 1'b1;
      2: sw_if.clear = 1'b1;
      default: begin sw_if.clear = 1'b1; sw_if.start_stop = 1'b1; end
    endcase
    @(posedge clk); #1;
    sw_if.start_stop = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
    case (which)
      0: model_start();
      1: if (m_mode != ST_IDLE) begin
           if (!m_lap_act) m_lap_sec = m_sec;
           m_lap_act = ~m_lap_act;
         end
      default: model_clear();
    endcase
    @(negedge clk);
    check_status("press");
  endtask

  task automatic check_sweep();
    logic [15:0] v;
    logic [3:0]  e_ctl;
    v = to_bcd(m_lap_act ? m_lap_sec : m_sec);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1 sw_if.scan = 2'(s);
      @(posedge clk);
      @(negedge clk);
      e_ctl = 4'b1111;
      e_ctl[s] = 1'b0;
      check_eq("sweep_ssd_ctl", 32'(sw_if.ssd_ctl), 32'(e_ctl));
      check_eq("sweep_bcd", 32'(sw_if.bcd), 32'(v[s*4 +: 4]));
    end
  endtask

  initial begin
    rst = 1'b1;
    sw_if.clk_1hz = 1'b0; sw_if.scan = 2'd0;
    sw_if.start_stop = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1 rst = 1'b0;

    // ticks without start leave the count alone
    repeat (3) tick_1hz(1'b0);
    check_eq("idle_time", 32'(sw_if.time_bcd), 32'h0000);

    // ten seconds of running
    press(0);
    repeat (10) tick_1hz(1'b0);
    check_eq("ten_sec", 32'(sw_if.time_bcd), 32'h0010);

    // run up to 59:59 then wrap
    while (m_sec != 3599) tick_1hz(1'b0);
    check_eq("at_5959", 32'(sw_if.time_bcd), 32'h5959);
    tick_1hz(1'b0);
    check_eq("wrapped_time", 32'(sw_if.time_bcd), 32'h0000);
    check_eq("wrapped_running", 32'(sw_if.running), 32'h1);

    // lap hold
    press(2);
    press(0);
    repeat (7) tick_1hz(1'b0);
    press(1);
    repeat (5) tick_1hz(1'b0);
    check_eq("lap_live", 32'(sw_if.time_bcd), 32'h0012);
    check_sweep();
    press(1);
    check_sweep();

    // start_stop coincident with tick, then clear beats start_stop
    press(2);
    press(0);
    repeat (3) tick_1hz(1'b0);
    tick_1hz(1'b1);
    check_eq("coinc_time", 32'(sw_if.time_bcd), 32'h0004);
    check_eq("coinc_state", 32'(sw_if.state_dbg), 32'(ST_PAUSE));
    repeat (2) tick_1hz(1'b0);
    press(3);

    // reset mid-run at 12:34 with lap held and a clk_1hz edge in flight
    press(0);
    press(1);
    while (m_sec != 754) tick_1hz(1'b0);
    check_eq("at_1234", 32'(sw_if.time_bcd), 32'h1234);
    @(posedge clk); #1 sw_if.clk_1hz = 1'b1;
    @(posedge clk); #1 rst = 1'b1; sw_if.clk_1hz = 1'b0;
    @(posedge clk); #1 rst = 1'b0; sw_if.start_stop = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset("midrun_rst");
    @(posedge clk); #1 sw_if.start_stop = 1'b0;
    model_start();
    repeat (6) @(negedge clk);
    check_status("no_stale_tick");

    // randomized phase
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 6) tick_1hz(r == 6);
      else if (r == 7 || r == 8) press(0);
      else if (r == 9) press(1);
      else if (r == 10) check_sweep();
      else press($urandom_range(2, 3));
    end
    check_sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
